// File: rtl/usr_irq_responder.sv
// User interrupt responder: captures a held interrupt request, validates it, waits a fixed
// service latency, issues one downstream message and answers the requester with ack or fail.
module usr_irq_responder #(
   parameter int NUM_FUNC = 4,
   parameter int LATENCY  = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic        axis_aclk,
   input  logic        mod_rst,
   input  logic        usr_irq_in_vld,
   input  logic [4:0]  usr_irq_in_vec,
   input  logic [7:0]  usr_irq_in_fnc,
   output logic        usr_irq_out_ack,
   output logic        usr_irq_out_fail,
   input  logic [31:0] vec_mask,
   output logic        msg_vld,
   output logic [4:0]  msg_vec,
   output logic [7:0]  msg_fnc,
   input  logic        msg_rdy,
   output logic [31:0] ack_cnt,
   output logic [31:0] fail_cnt,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ISSUE,
      RESP,
      DRAIN
   } state_t;

   localparam logic [15:0] LAT_L = 16'(LATENCY);
   localparam logic [15:0] TO_L  = 16'(TIMEOUT);
   localparam logic [31:0] NF_L  = NUM_FUNC;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        ack_nxt;
   logic        fail_nxt;
   logic        msg_vld_nxt;
   logic [4:0]  msg_vec_nxt;
   logic [7:0]  msg_fnc_nxt;
   logic        cap_en;
   logic        req_bad;
   logic [4:0]  cap_vec;
   logic [7:0]  cap_fnc;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Rejection is decided on the live inputs in the capture cycle only.
   assign req_bad = ({24'd0, usr_irq_in_fnc} >= NF_L) || vec_mask[usr_irq_in_vec];

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ack_nxt     = 1'b0;
      fail_nxt    = 1'b0;
      msg_vld_nxt = msg_vld;
      msg_vec_nxt = msg_vec;
      msg_fnc_nxt = msg_fnc;
      cap_en      = 1'b0;
      case (state)
         IDLE: begin
            if (usr_irq_in_vld) begin
               cap_en = 1'b1;
               if (req_bad) begin
                  state_nxt = RESP;
                  fail_nxt  = 1'b1;
               end else if (LAT_L == 16'd0) begin
                  state_nxt   = ISSUE;
                  cnt_nxt     = 16'd0;
                  msg_vld_nxt = 1'b1;
                  msg_vec_nxt = usr_irq_in_vec;
                  msg_fnc_nxt = usr_irq_in_fnc;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_L;
               end
            end
         end
         WAIT: begin
            if (cnt <= 16'd1) begin
               state_nxt   = ISSUE;
               cnt_nxt     = 16'd0;
               msg_vld_nxt = 1'b1;
               msg_vec_nxt = cap_vec;
               msg_fnc_nxt = cap_fnc;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ISSUE: begin
            // A transfer on the same edge as the timeout still counts as delivered.
            if (msg_rdy) begin
               state_nxt   = RESP;
               ack_nxt     = 1'b1;
               msg_vld_nxt = 1'b0;
               cnt_nxt     = 16'd0;
            end else if ((cnt + 16'd1) >= TO_L) begin
               state_nxt   = RESP;
               fail_nxt    = 1'b1;
               msg_vld_nxt = 1'b0;
               cnt_nxt     = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         RESP: begin
            state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!usr_irq_in_vld) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_aclk or posedge mod_rst) begin
      if (mod_rst) begin
         state            <= IDLE;
         cnt              <= 16'd0;
         usr_irq_out_ack  <= 1'b0;
         usr_irq_out_fail <= 1'b0;
         msg_vld          <= 1'b0;
         msg_vec          <= 5'd0;
         msg_fnc          <= 8'd0;
         busy             <= 1'b0;
         ack_cnt          <= 32'd0;
         fail_cnt         <= 32'd0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         usr_irq_out_ack  <= ack_nxt;
         usr_irq_out_fail <= fail_nxt;
         msg_vld          <= msg_vld_nxt;
         msg_vec          <= msg_vec_nxt;
         msg_fnc          <= msg_fnc_nxt;
         busy             <= (state_nxt != IDLE);
         if (ack_nxt) begin
            ack_cnt <= sat_inc(ack_cnt);
         end
         if (fail_nxt) begin
            fail_cnt <= sat_inc(fail_cnt);
         end
      end
   end

   // Holding registers are pure data: only meaningful after a capture.
   always_ff @(posedge axis_aclk) begin
      if (cap_en) begin
         cap_vec <= usr_irq_in_vec;
         cap_fnc <= usr_irq_in_fnc;
      end
   end

endmodule
